// File: rtl/counter_bank.sv
// Bank of step accumulators with wrap/saturate arithmetic, sticky overflow,
// an atomic snapshot streamed over valid/ready, and a free-running heartbeat.
module counter_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 16,
    parameter int HB_WIDTH = 32,
    parameter int HB_BITS  = 8,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sat_mode,
    input  logic                clear,
    input  logic                cfg_we,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]    cfg_step,
    input  logic                snap_req,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHAN_W-1:0]   out_chan,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf,
    output logic                out_last,
    output logic [HB_BITS-1:0]  hb_out
);

    // Stream handshake: a beat transfers on any rising edge where out_valid
    // and out_ready are both high; while out_valid && !out_ready every out_*
    // output holds its value.

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(CHANNELS - 1);

    state_t              state;
    logic [WIDTH-1:0]    acc    [CHANNELS];
    logic [WIDTH-1:0]    step   [CHANNELS];
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH:0]      sum    [CHANNELS];
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] shadow_ovf;
    logic [HB_WIDTH-1:0] hb;
    logic [CHAN_W-1:0]   idx;
    logic [CHAN_W-1:0]   next_idx;
    logic                step_hit;

    assign hb_out   = hb[HB_WIDTH-1 -: HB_BITS];
    assign next_idx = idx + 1'b1;
    assign step_hit = cfg_we && (int'(cfg_chan) < CHANNELS);

    // One extra bit so the carry out of each channel is visible.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, step[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]  <= '0;
                step[i] <= WIDTH'(i);
                ovf[i]  <= 1'b0;
            end
            hb <= '0;
        end else begin
            hb <= hb + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear) begin
                    acc[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (en) begin
                    if (sum[i][WIDTH]) begin
                        acc[i] <= sat_mode ? {WIDTH{1'b1}} : sum[i][WIDTH-1:0];
                        ovf[i] <= 1'b1;
                    end else begin
                        acc[i] <= sum[i][WIDTH-1:0];
                    end
                end
            end
            // The accumulate above reads the old step on this same edge.
            if (step_hit) begin
                step[cfg_chan] <= cfg_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            out_last   <= 1'b0;
            shadow_ovf <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            shadow[i] <= acc[i];
                        end
                        shadow_ovf <= ovf;
                        state      <= STREAM;
                        idx        <= '0;
                        busy       <= 1'b1;
                        out_valid  <= 1'b1;
                        out_chan   <= '0;
                        out_data   <= acc[0];
                        out_ovf    <= ovf[0];
                        out_last   <= (LAST_IDX == CHAN_W'(0));
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            idx       <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_chan  <= '0;
                            out_data  <= '0;
                            out_ovf   <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= next_idx;
                            out_chan <= next_idx;
                            out_data <= shadow[next_idx];
                            out_ovf  <= shadow_ovf[next_idx];
                            out_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: directed table of accumulate scenarios, hand-written
// stream corner cases, and random traffic checked against a behavioural model.
module tb_counter_bank;

  localparam int CH  = 8;
  localparam int W   = 16;
  localparam int HBW = 12;
  localparam int HBB = 8;

  logic        clk = 1'b0;
  logic        rst, en, sat_mode, clear, cfg_we, snap_req, out_ready;
  logic [2:0]  cfg_chan;
  logic [15:0] cfg_step;
  logic        busy, out_valid, out_ovf, out_last;
  logic [2:0]  out_chan;
  logic [15:0] out_data;
  logic [7:0]  hb_out;

  counter_bank #(.CHANNELS(CH), .WIDTH(W), .HB_WIDTH(HBW), .HB_BITS(HBB)) dut (
    .clk(clk), .rst(rst), .en(en), .sat_mode(sat_mode), .clear(clear),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_step(cfg_step),
    .snap_req(snap_req), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
    .out_ovf(out_ovf), .out_last(out_last), .hb_out(hb_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int  vectors = 0;
  int  miscompares = 0;
  int  m_acc [CH];
  int  m_step[CH];
  bit  m_ovf [CH];
  int  m_hb;
  bit  m_live = 1'b0;
  int  hs_count = 0;
  logic [19:0] exp_q[$];  // {chan, ovf, data} of each beat still to come

  logic [15:0] got_data[CH];
  bit          got_ovf [CH];
  int          got_beats, last_cnt, last_chan;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit was_empty;
    int s;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_acc[i] = 0; m_ovf[i] = 1'b0; m_step[i] = i;
      end
      m_hb = 0;
      exp_q.delete();
      m_live = 1'b1;
      return;
    end
    m_hb = (m_hb + 1) % (1 << HBW);
    was_empty = (exp_q.size() == 0);
    if (!was_empty && out_ready) void'(exp_q.pop_front());
    if (was_empty && snap_req)
      for (int i = 0; i < CH; i++) exp_q.push_back({3'(i), m_ovf[i], 16'(m_acc[i])});
    if (clear) begin
      for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
    end else if (en) begin
      for (int i = 0; i < CH; i++) begin
        s = m_acc[i] + m_step[i];
        if (s > 65535) begin
          m_ovf[i] = 1'b1;
          m_acc[i] = sat_mode ? 65535 : s - 65536;
        end else begin
          m_acc[i] = s;
        end
      end
    end
    if (cfg_we && int'(cfg_chan) < CH) m_step[cfg_chan] = int'(cfg_step);
  endtask

  task automatic check_outputs();
    logic [19:0] e;
    if (!m_live) return;
    chk("busy", 32'(busy), 32'(exp_q.size() > 0));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("hb_out", 32'(hb_out), 32'(m_hb >> (HBW - HBB)));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_chan", 32'(out_chan), 32'(e[19:17]));
      chk("out_ovf", 32'(out_ovf), 32'(e[16]));
      chk("out_data", 32'(out_data), 32'(e[15:0]));
      chk("out_last", 32'(out_last), 32'(e[19:17] == 3'd7));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_count++;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; cfg_we = 1'b0; snap_req = 1'b0;
    sat_mode = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    got_beats = 0; last_cnt = 0; last_chan = -1;
    for (int i = 0; i < CH; i++) begin got_data[i] = 'x; got_ovf[i] = 1'b0; end
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        got_data[out_chan] = out_data;
        got_ovf[out_chan]  = out_ovf;
        got_beats++;
        if (out_last) begin last_cnt++; last_chan = int'(out_chan); end
      end else if (got_beats > 0) begin
        break;
      end
      tick();
    end
  endtask

  task automatic snap_and_drain();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    drain();
    chk("beats", 32'(got_beats), 32'(CH));
  endtask

  task automatic wait_chan(input logic [2:0] c);
    for (int k = 0; k < 20; k++) begin
      if (out_valid && out_chan == c) break;
      tick();
    end
    chk("reach_chan", 32'(out_valid && out_chan == c), 32'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [2:0]  chan;
    logic [15:0] stp;
    bit          sat;
    int          n;
    int          look;
    logic [15:0] exp_d;
    bit          exp_o;
  } vec_t;

  vec_t tbl[11];
  int   hs0;

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 10, 5, 16'd50,   1'b0};
    tbl[1]  = '{1'b1, 3'd3, 16'h8000, 1'b0, 3,  3, 16'h8000, 1'b1};
    tbl[2]  = '{1'b1, 3'd3, 16'h8000, 1'b0, 3,  0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 16'h7000, 1'b1, 3,  2, 16'hFFFF, 1'b1};
    tbl[4]  = '{1'b1, 3'd2, 16'h7000, 1'b1, 2,  2, 16'hE000, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 16'h7000, 1'b1, 5,  2, 16'hFFFF, 1'b1};
    tbl[6]  = '{1'b1, 3'd2, 16'h7000, 1'b0, 3,  2, 16'h5000, 1'b1};
    tbl[7]  = '{1'b1, 3'd7, 16'h0000, 1'b1, 20, 7, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 3'd1, 16'hFFFF, 1'b0, 2,  1, 16'hFFFE, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 16'hFFFF, 1'b1, 1,  1, 16'hFFFF, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 5,  6, 16'd30,   1'b0};

    rst = 1'b1; en = 1'b0; sat_mode = 1'b0; clear = 1'b0; cfg_we = 1'b0;
    cfg_chan = '0; cfg_step = '0; snap_req = 1'b0; out_ready = 1'b1;
    #1;

    // Reset state.
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_hb", 32'(hb_out), 32'd0);

    // Heartbeat top bits after 16 cycles.
    repeat (16) tick();
    chk("hb_16", 32'(hb_out), 32'h01);

    for (int t = 0; t < 11; t++) begin
      do_reset();
      if (tbl[t].wr) begin
        cfg_we = 1'b1; cfg_chan = tbl[t].chan; cfg_step = tbl[t].stp;
        tick();
        cfg_we = 1'b0;
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sat_mode = tbl[t].sat;
      en = 1'b1;
      repeat (tbl[t].n) tick();
      en = 1'b0;
      snap_and_drain();
      chk($sformatf("tbl%0d_data", t), 32'(got_data[tbl[t].look]), 32'(tbl[t].exp_d));
      chk($sformatf("tbl%0d_ovf", t), 32'(got_ovf[tbl[t].look]), 32'(tbl[t].exp_o));
    end

    // Basic stream: 10 enabled cycles, every channel reads 10*i.
    do_reset();
    en = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    snap_and_drain();
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("base_data%0d", i), 32'(got_data[i]), 32'(10 * i));
      chk($sformatf("base_ovf%0d", i), 32'(got_ovf[i]), 32'd0);
    end
    chk("base_last_cnt", 32'(last_cnt), 32'd1);
    chk("base_last_chan", 32'(last_chan), 32'd7);
    chk("base_busy_after", 32'(busy), 32'd0);

    // Backpressure at channel 4 with an ignored snap_req pulse.
    do_reset();
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    hs0 = hs_count;
    out_ready = 1'b1;
    wait_chan(3'd4);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      snap_req = (k == 2);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_chan", 32'(out_chan), 32'd4);
      chk("bp_data", 32'(out_data), 32'd12);
    end
    snap_req = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_valid; k++) tick();
    chk("bp_beats", 32'(hs_count - hs0), 32'(CH));
    repeat (3) tick();
    chk("bp_no_requeue", 32'(busy), 32'd0);

    // clear and snap_req on the same edge.
    do_reset();
    en = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    clear = 1'b1; snap_req = 1'b1;
    tick();
    clear = 1'b0; snap_req = 1'b0;
    drain();
    for (int i = 0; i < CH; i++)
      chk($sformatf("clrsnap_data%0d", i), 32'(got_data[i]), 32'(4 * i));
    snap_and_drain();
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("post_clr_data%0d", i), 32'(got_data[i]), 32'd0);
      chk($sformatf("post_clr_ovf%0d", i), 32'(got_ovf[i]), 32'd0);
    end

    // Reset mid-stream at beat 2.
    do_reset();
    sat_mode = 1'b0;
    cfg_we = 1'b1; cfg_chan = 3'd5; cfg_step = 16'h1234;
    tick();
    cfg_we = 1'b0;
    en = 1'b1;
    repeat (2) tick();
    en = 1'b0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    wait_chan(3'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    snap_and_drain();
    for (int i = 0; i < CH; i++)
      chk($sformatf("midrst_acc%0d", i), 32'(got_data[i]), 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    snap_and_drain();
    for (int i = 0; i < CH; i++)
      chk($sformatf("midrst_step%0d", i), 32'(got_data[i]), 32'(i));

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 3000; r++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 3) != 0);
      sat_mode = ($urandom_range(0, 1) == 1);
      clear    = ($urandom_range(0, 40) == 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_chan = 3'($urandom_range(0, 7));
      cfg_step = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                             : 16'($urandom_range(0, 16'h0FFF));
      snap_req  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
